// File: rtl/rotl_pipe_pkg.sv
// Shared definitions for the pipelined left-rotate shifter.
//   DEF_WIDTH : default data width
//   clog2()   : constant function used to derive the stage count
//   rotl()    : reference left-rotate at DEF_WIDTH, for models and scoreboards
package rotl_pipe_pkg;

  localparam int DEF_WIDTH = 8;

  // Smallest r such that 2**r >= v.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Rotate left by n: y[i] = d[(i - n) mod WIDTH].
  function automatic logic [DEF_WIDTH-1:0] rotl(input logic [DEF_WIDTH-1:0] d,
                                                input int unsigned          n);
    logic [DEF_WIDTH-1:0] r;
    int unsigned          nm;
    nm = n % DEF_WIDTH;
    for (int i = 0; i < DEF_WIDTH; i++) begin
      r[i] = d[(i + DEF_WIDTH - nm) % DEF_WIDTH];
    end
    return r;
  endfunction

endpackage

// File: rtl/rotl_pipe_stage.sv
// One pipeline stage of rotl_pipe: rotates by 2**STAGE when amt bit STAGE is
// set, registers the result together with the rotate amount and a valid flag.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : upstream handshake
//   in_data/in_amt        : upstream data and rotate amount
//   out_valid/out_ready   : downstream handshake
//   out_data/out_amt      : registered data and rotate amount
module rotl_stage #(
  parameter int WIDTH   = 8,
  parameter int SHIFT_W = 3,
  parameter int STAGE   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHIFT_W-1:0] in_amt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SHIFT_W-1:0] out_amt
);

  localparam int SH = 1 << STAGE;

  logic               valid_q;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHIFT_W-1:0] amt_q;
  logic [WIDTH-1:0]   rot_data;

  // Fixed rotate by SH: the top SH bits wrap around to the bottom.
  assign rot_data = {in_data[WIDTH-1-SH:0], in_data[WIDTH-1:WIDTH-SH]};
  assign data_d   = in_amt[STAGE] ? rot_data : in_data;

  // An empty slot always accepts; a full one accepts only if it is emptying
  // this cycle, which collapses bubbles while the consumer is stalled.
  assign in_ready = !valid_q || out_ready;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its upstream neighbour's pre-edge value, giving a true pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      // Payload only moves with a real item; a bubble leaves it untouched.
      if (in_valid) begin
        data_q <= data_d;
        amt_q  <= in_amt;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_amt   = amt_q;

endmodule

// File: rtl/rotl_pipe.sv
// Pipelined left-rotate barrel shifter, one log2 stage per register, with
// valid/ready handshakes on both sides. Inverse of the rotate-right shifter.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake for a/amt
//   a, amt               : data and left-rotate amount (0..WIDTH-1)
//   out_valid/out_ready  : output handshake for y
//   y                    : registered result, a rotated left by amt
module rotl_pipe
  import rotl_pipe_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  localparam int SHIFT_W = clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHIFT_W-1:0] amt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y
);

  // Index k is the input of stage k; index SHIFT_W is the pipe output.
  logic               valid_chain [SHIFT_W+1];
  logic               ready_chain [SHIFT_W+1];
  logic [WIDTH-1:0]   data_chain  [SHIFT_W+1];
  logic [SHIFT_W-1:0] amt_chain   [SHIFT_W+1];
  logic [SHIFT_W-1:0] amt_unused;

  assign valid_chain[0]       = in_valid;
  assign data_chain[0]        = a;
  assign amt_chain[0]         = amt;
  assign ready_chain[SHIFT_W] = out_ready;

  for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
    rotl_stage #(
      .WIDTH  (WIDTH),
      .SHIFT_W(SHIFT_W),
      .STAGE  (k)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .in_valid (valid_chain[k]),
      .in_ready (ready_chain[k]),
      .in_data  (data_chain[k]),
      .in_amt   (amt_chain[k]),
      .out_valid(valid_chain[k+1]),
      .out_ready(ready_chain[k+1]),
      .out_data (data_chain[k+1]),
      .out_amt  (amt_chain[k+1])
    );
  end

  // The rotate amount is fully consumed by the last stage.
  assign amt_unused = amt_chain[SHIFT_W];

  assign in_ready  = ready_chain[0];
  assign out_valid = valid_chain[SHIFT_W];
  assign y         = data_chain[SHIFT_W];

endmodule

// File: tb/tb_rotl_pipe.sv
// Self-checking bench for rotl_pipe: directed steps with a scoreboard queue.
module tb_rotl_pipe;
  import rotl_pipe_pkg::*;

  localparam int W  = DEF_WIDTH;
  localparam int SW = clog2(W);

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [SW-1:0] amt;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  y;

  rotl_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .amt      (amt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           n_out = 0;
  int           cyc   = 0;
  int           acc_cyc = 0;
  logic         acc;
  logic [W-1:0] exp_y;
  logic [W-1:0] sb_q [$];

  // Reference rotate-right, standing in for the existing shifter.
  function automatic logic [W-1:0] rotr(input logic [W-1:0] d, input int unsigned n);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = d[(i + n) % W];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: evaluate both handshakes against the settled inputs,
  // update the scoreboard, then advance to the next falling edge.
  task automatic step();
    #1;
    acc = 1'b0;
    if (!reset) begin
      if (out_valid && out_ready) begin
        n_out++;
        n_cmp++;
        assert (sb_q.size() != 0) else begin
          n_bad++;
          $error("FAIL unexpected_out: observed y=%0h with empty scoreboard", y);
        end
        if (sb_q.size() != 0) check("y", y, sb_q.pop_front());
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(exp_y);
        acc     = 1'b1;
        acc_cyc = cyc;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input logic [W-1:0] d, input logic [SW-1:0] n, input logic [W-1:0] e);
    in_valid = 1'b1;
    a        = d;
    amt      = n;
    exp_y    = e;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) step();
    check("drain_empty", sb_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [W-1:0]  bp_a   [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [SW-1:0] bp_amt [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

  initial begin
    int           idx;
    int           out0;
    logic [W-1:0] y_hold;
    logic [W-1:0] ra;

    reset = 1'b1; in_valid = 1'b0; a = '0; amt = '0; out_ready = 1'b1; exp_y = '0;
    @(negedge clk);

    // 1. Reset values, then single item latency.
    check("rst_y", y, 0);
    check("rst_out_valid", out_valid, 0);
    step();
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    drive(8'h01, 3'd3, 8'h08);
    step();
    check("t1_accept", acc, 1);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) step();
    check("t1_out_valid", out_valid, 1);
    check("t1_latency", cyc - acc_cyc, SW);
    drain();

    // 2. Wrap-around, back-to-back, consecutive outputs.
    drive(8'h81, 3'd1, 8'h03); step();
    drive(8'h80, 3'd7, 8'h40); step();
    drive(8'hA5, 3'd0, 8'hA5); step();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) step();
    for (int i = 0; i < 3; i++) begin
      check("t2_consecutive_valid", out_valid, 1);
      step();
    end
    check("t2_valid_after", out_valid, 0);
    check("t2_sb_empty", sb_q.size(), 0);

    // 3. Backpressure: only SHIFT_W items fit, then in_ready drops.
    out_ready = 1'b0;
    idx = 0;
    out0 = n_out;
    for (int c = 0; c < 8; c++) begin
      drive(bp_a[idx], bp_amt[idx], rotl(bp_a[idx], bp_amt[idx]));
      step();
      if (acc) idx++;
    end
    check("t3_accepted", idx, SW);
    #1;
    check("t3_in_ready_low", in_ready, 0);
    check("t3_out_valid", out_valid, 1);
    check("t3_head", y, rotl(bp_a[0], bp_amt[0]));
    y_hold = y;
    for (int c = 0; c < 3; c++) begin
      step();
      check("t3_y_stable", y, y_hold);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 30 && !(idx == 5 && sb_q.size() == 0); c++) begin
      if (idx < 5) drive(bp_a[idx], bp_amt[idx], rotl(bp_a[idx], bp_amt[idx]));
      else in_valid = 1'b0;
      step();
      if (acc) idx++;
    end
    check("t3_all_accepted", idx, 5);
    check("t3_out_count", n_out - out0, 5);
    drain();

    // 4. Full pipe: one in and one out every cycle.
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10 && idx < SW; c++) begin
      ra = W'($urandom);
      drive(ra, SW'(c), rotl(ra, c));
      step();
      if (acc) idx++;
    end
    check("t4_filled", idx, SW);
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      ra = W'($urandom);
      drive(ra, SW'($urandom_range(0, W - 1)), '0);
      exp_y = rotl(a, amt);
      #1;
      check("t4_in_ready", in_ready, 1);
      check("t4_out_valid", out_valid, 1);
      step();
    end
    drain();

    // 5. Reset with three items in flight.
    out_ready = 1'b0;
    drive(8'h12, 3'd1, 8'h24); step();
    drive(8'h34, 3'd2, 8'hD0); step();
    drive(8'h56, 3'd3, 8'hB2); step();
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb_q.delete();
    check("t5_out_valid_cleared", out_valid, 0);
    check("t5_y_cleared", y, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check("t5_no_ghost", out_valid, 0);
    end
    out0 = n_out;
    drive(8'hC3, 3'd2, 8'h0F);
    step();
    drain();
    check("t5_next_item", n_out - out0, 1);

    // 6. Inverse property over every (a, n) with random backpressure.
    out0 = n_out;
    for (int v = 0; v < 256; v++) begin
      for (int n = 0; n < W; n++) begin
        drive(rotr(W'(v), n), SW'(n), W'(v));
        for (int t = 0; t < 64; t++) begin
          out_ready = 1'($urandom_range(0, 1));
          step();
          if (acc) break;
        end
        if (!acc) check("t6_accept", acc, 1);
      end
    end
    drain();
    check("t6_count", n_out - out0, 256 * W);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rotl_pipe.md
Name: rotl_pipe

Overview:
Pipelined left-rotate barrel shifter. It is the inverse-direction counterpart to the team's combinational rotate-right shifter: rotl(rotr(a,n),n) == a.
- One log stage per register, with valid/ready handshaking on both sides.
- Sits between a streaming producer and consumer in datapath blocks that must undo a prior right rotation at full clock rate.

Parameters:
WIDTH, 8, data width in bits; must be a power of 2, >= 2
SHIFT_W, log2(WIDTH) = 3, width of amt and number of pipeline stages (derived, not overridden)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  a/amt valid this cycle
in_ready  out  1  block can accept a/amt this cycle
a  in  WIDTH  data to rotate
amt  in  SHIFT_W  left-rotate amount, 0..WIDTH-1
out_valid  out  1  y valid
out_ready  in  1  consumer accepts y this cycle
y  out  WIDTH  a rotated left by amt

Behaviour:
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Stage structure: stage k (k = 0..SHIFT_W-1) holds valid_k, data_k and the remaining amt bits.
  - On load, stage k applies a rotate-left by 2^k when amt bit k = 1, else passes data unchanged.
  - Stage 0 rotates the incoming a by 1.
  - Stage 1 rotates stage-0 data by 2.
  - Stage 2 rotates by 4; in general, stage k rotates by 2^k.
- Rotate-left by n: y[i] = d[(i - n) mod WIDTH]. For example, {d[WIDTH-2:0], d[WIDTH-1]} for n = 1.
- Per-stage ready (bubble-collapsing):
  - ready_k = !valid_k || ready_(k+1), with ready_SHIFT_W = out_ready.
  - in_ready = ready_0.
  - Stage k loads when ready_k. valid_k <= valid_(k-1) (in_valid for k = 0).
  - Data/amt registers load only when the upstream valid is 1; otherwise they hold.
- Outputs:
  - out_valid = valid_(SHIFT_W-1).
  - y = data_(SHIFT_W-1). y is registered; no combinational path from a to y.
- Latency: exactly SHIFT_W cycles (3 at default) from input transfer to out_valid with no stall.
- Throughput: 1 per cycle when out_ready is held high.
- Backpressure:
  - With out_ready low, the pipeline fills. At most SHIFT_W items are held.
  - in_ready drops only when all stages are valid and out_ready = 0.
  - Bubbles in the pipeline are squeezed out while stalled.
- Order and data: items leave in the order accepted. No item is dropped or duplicated.
- Output stability: y stays stable while out_valid && !out_ready.
- Simultaneous events: when the pipeline is full and out_ready = 1, in_ready = 1 in the same cycle. One item enters and one leaves.
- amt = 0 passes the data through unchanged, with the same latency.
- Reset:
  - All valid_k <= 0 and all data/amt registers <= 0, so out_valid = 0 and y = 0.
  - in_ready = 1 in the first cycle after reset deasserts.
  - Reset mid-operation discards all in-flight items; no partial output emerges.
- Input validity: a, amt and in_valid are ignored while reset = 1.

Decomposition:
- Shared package:
  - WIDTH default.
  - A clog2 constant function used to derive SHIFT_W.
  - A rotl reference function for the bench scoreboard.
- One sub-module, rotl_stage, parameterized by WIDTH, SHIFT_W and STAGE (0..SHIFT_W-1).
  - Ports: clk, reset, in_valid/in_ready/data/amt, out_valid/out_ready/data/amt.
  - Holds the registered data, amt and valid, plus the ready_k logic above.
  - rotl_pipe instantiates SHIFT_W copies through a generate loop and chains them.

Test Plan:
1. Reset, then a = 8'h01, amt = 3, out_ready = 1 -> out_valid rises exactly 3 cycles after accept; y = 8'h08. Check y = 0 and out_valid = 0 during reset.
2. Wrap-around: a = 8'h81 amt = 1 -> y = 8'h03; a = 8'h80 amt = 7 -> y = 8'h40; a = 8'hA5 amt = 0 -> y = 8'hA5. Issue back-to-back; outputs appear on 3 consecutive cycles.
3. Backpressure: out_ready = 0, offer 5 items -> exactly 3 accepted, then in_ready = 0. Raise out_ready -> all 5 emerge in order with correct values, y stable while stalled.
4. Full-pipe simultaneous transfer: pipeline full, out_ready = 1 and in_valid = 1 same cycle -> in_ready = 1. One in and one out per cycle for 10 cycles; no gaps in out_valid.
5. Reset mid-stream: 3 items in flight, assert reset 1 cycle -> out_valid = 0 next cycle; none of the 3 items ever appears; the next accepted item has a correct result.
6. Inverse property: drive all 256 × 8 (a, n) pairs through the existing rotate-right shifter, then rotl_pipe with amt = n, random out_ready -> y == a for every pair, scoreboard count = 2048.
